// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared types and constants for the activation pipeline
package activation_pkg;

   typedef enum logic [2:0] {
      ACT_RELU    = 3'd0,
      ACT_TANH    = 3'd1,
      ACT_SIGMOID = 3'd2,
      ACT_NONE    = 3'd3,
      ACT_LEAKY   = 3'd4
   } act_type_e;

   // leaky ReLU negative slope is 1/8
   localparam int LEAKY_SHIFT = 3;

   // knots and offsets expressed as NUM/DEN fractions of ONE
   localparam int TANH_LO_NUM     = 1;
   localparam int TANH_LO_DEN     = 2;
   localparam int TANH_HI_NUM     = 3;
   localparam int TANH_HI_DEN     = 2;
   localparam int TANH_BIAS_NUM   = 1;
   localparam int TANH_BIAS_DEN   = 4;
   localparam int SIG_KNOT_NUM    = 2;
   localparam int SIG_KNOT_DEN    = 1;
   localparam int SIG_MID_NUM     = 1;
   localparam int SIG_MID_DEN     = 2;
   localparam int SIG_SLOPE_SHIFT = 2;

   function automatic int frac_of_one(input int one, input int num, input int den);
      return (one * num) / den;
   endfunction

endpackage

// File: rtl/act_lane.sv
// rtl/act_lane.sv - one-lane activation, requantise and saturate datapath
module act_lane
   import activation_pkg::*;
#(
   parameter int IN_W       = 16,
   parameter int IN_FRAC    = 8,
   parameter int OUT_W      = 8,
   parameter int OUT_FRAC   = 4,
   parameter int OUT_SIGNED = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld1,
   input  logic             ld2,
   input  logic [2:0]       act_type,
   input  logic             mask,
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   // two guard bits: one for |most-negative|, one for the rounding add
   localparam int A     = IN_W + 2;
   localparam int S     = IN_FRAC - OUT_FRAC;
   localparam int ONE_I = 1 << IN_FRAC;
   localparam int RND_I = (1 << S) >> 1;
   localparam int MAX_I = (OUT_SIGNED != 0) ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
   localparam int MIN_I = (OUT_SIGNED != 0) ? -(1 << (OUT_W - 1)) : 0;

   localparam logic signed [A-1:0] ONE       = A'(ONE_I);
   localparam logic signed [A-1:0] TANH_LO   = A'(frac_of_one(ONE_I, TANH_LO_NUM, TANH_LO_DEN));
   localparam logic signed [A-1:0] TANH_HI   = A'(frac_of_one(ONE_I, TANH_HI_NUM, TANH_HI_DEN));
   localparam logic signed [A-1:0] TANH_BIAS = A'(frac_of_one(ONE_I, TANH_BIAS_NUM, TANH_BIAS_DEN));
   localparam logic signed [A-1:0] SIG_HI    = A'(frac_of_one(ONE_I, SIG_KNOT_NUM, SIG_KNOT_DEN));
   localparam logic signed [A-1:0] SIG_MID   = A'(frac_of_one(ONE_I, SIG_MID_NUM, SIG_MID_DEN));
   localparam logic signed [A-1:0] RND       = A'(RND_I);
   localparam logic signed [A-1:0] MAX_V     = A'(MAX_I);
   localparam logic signed [A-1:0] MIN_V     = A'(MIN_I);

   logic signed [A-1:0] xs, ax, mag, f, s1_f, r;
   logic                neg, st;
   logic [OUT_W-1:0]    q;

   // S1 combinational: piecewise activation at full input precision
   always_comb begin
      xs  = {{2{x[IN_W-1]}}, x};
      neg = x[IN_W-1];
      ax  = neg ? -xs : xs;
      mag = TANH_BIAS + (ax >>> 1);
      f   = xs;
      case (act_type)
         ACT_RELU:  f = neg ? '0 : xs;
         ACT_LEAKY: f = neg ? (xs >>> LEAKY_SHIFT) : xs;
         ACT_TANH: begin
            if (ax < TANH_LO)      f = xs;
            else if (ax < TANH_HI) f = neg ? -mag : mag;
            else                   f = neg ? -ONE : ONE;
         end
         ACT_SIGMOID: begin
            if (xs >= SIG_HI)       f = ONE;
            else if (xs <= -SIG_HI) f = '0;
            else                    f = SIG_MID + (xs >>> SIG_SLOPE_SHIFT);
         end
         default:   f = xs;
      endcase
   end

   // S1 register holds the activation result of the beat in stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   s1_f <= '0;
      else if (ld1) s1_f <= f;
   end

   // S2 combinational: round half up, drop fraction bits, clamp to output range
   always_comb begin
      r  = (s1_f + RND) >>> S;
      st = 1'b0;
      q  = r[OUT_W-1:0];
      if (r > MAX_V) begin
         q  = MAX_V[OUT_W-1:0];
         st = 1'b1;
      end else if (r < MIN_V) begin
         q  = MIN_V[OUT_W-1:0];
         st = 1'b1;
      end
   end

   // S2 register: masked lanes emit zero and never report saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y   <= '0;
         sat <= 1'b0;
      end else if (ld2) begin
         y   <= mask ? q : '0;
         sat <= mask & st;
      end
   end

endmodule

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - multi-lane two-stage activation pipeline with flow control
module activation_pipe
   import activation_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int IN_W       = 16,
   parameter int IN_FRAC    = 8,
   parameter int OUT_W      = 8,
   parameter int OUT_FRAC   = 4,
   parameter int OUT_SIGNED = 1,
   parameter int CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2:0]             act_type,
   input  logic [LANES-1:0]       lane_mask,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       out_sat,
   input  logic                   sat_clr,
   output logic [CNT_W-1:0]       sat_count
);

   localparam int PW = $clog2(LANES + 1);

   logic             s1_valid, s2_valid, s2_free, s1_ld, s2_ld, fire;
   logic [LANES-1:0] s1_mask;
   logic [PW-1:0]    pop;
   logic [CNT_W:0]   sum;

   assign s2_free   = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_free;
   assign s1_ld     = in_valid && in_ready;
   assign s2_ld     = s1_valid && s2_free;
   assign out_valid = s2_valid;
   assign fire      = s2_valid && out_ready;

   // stage occupancy; the mask rides with the beat, the type is consumed in S1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_mask  <= '0;
      end else begin
         if (s1_ld)        s1_valid <= 1'b1;
         else if (s2_free) s1_valid <= 1'b0;
         if (s2_free)      s2_valid <= s1_valid;
         if (s1_ld)        s1_mask  <= lane_mask;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      act_lane #(
         .IN_W      (IN_W),
         .IN_FRAC   (IN_FRAC),
         .OUT_W     (OUT_W),
         .OUT_FRAC  (OUT_FRAC),
         .OUT_SIGNED(OUT_SIGNED)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .ld1     (s1_ld),
         .ld2     (s2_ld),
         .act_type(act_type),
         .mask    (s1_mask[g]),
         .x       (in_data[g*IN_W +: IN_W]),
         .y       (out_data[g*OUT_W +: OUT_W]),
         .sat     (out_sat[g])
      );
   end

   // number of saturated lanes in the beat currently at the output
   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) pop = pop + PW'(out_sat[i]);
      sum = {1'b0, sat_count} + {{(CNT_W + 1 - PW){1'b0}}, pop};
   end

   // saturation event counter: clear wins, otherwise sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sat_count <= '0;
      else if (sat_clr) sat_count <= '0;
      else if (fire)    sat_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end

endmodule
